// File: rtl/text_loader_if.sv
// rtl/text_loader_if.sv - boot stream, text-memory write and status bundle for text_loader
//
// Purpose: groups the byte-stream handshake, the text-memory write port and
// the boot status lines into one bundle.
//   master : the boot source side (drives start/in_data/in_valid, observes the rest)
//   slave  : the loader (text_loader)
// Signals:
//   start      one-cycle (re)load request
//   in_data    stream byte, in_valid qualifies it, in_ready = loader can accept
//   mem_data   16-bit word to text memory, mem_addr byte address, mem_we write enable
//   cpu_reset  hold the core in reset while high
//   done       image loaded and checksum good
//   error      checksum mismatch
//   word_count words written in the current load
interface text_loader_if;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mem_data;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, mem_data, mem_addr, mem_we, cpu_reset, done, error, word_count
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, mem_data, mem_addr, mem_we, cpu_reset, done, error, word_count
  );
endinterface

// File: rtl/text_loader.sv
// rtl/text_loader.sv - boot-time loader writing a checksummed byte stream into text memory
//
// Purpose: receives a little-endian stream (len_lo, len_hi, len word pairs,
// XOR checksum byte), writes each assembled 16-bit word to consecutive even
// byte addresses starting at BASE_ADDR, and releases the CPU from reset only
// once the checksum matches.
// Ports:
//   clk    system clock, all state updates on posedge
//   reset  asynchronous active-high reset
//   bus    text_loader_if.slave: stream in, memory write out, boot status out
// Parameters:
//   BASE_ADDR   byte address of the first word written
//   AUTO_START  nonzero = begin a load on the first clock after reset
module text_loader #(
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter int          AUTO_START = 1
) (
  input  logic         clk,
  input  logic         reset,
  text_loader_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q;
  logic        in_ready_q;
  logic        mem_we_q;
  logic [15:0] mem_data_q;
  logic [15:0] mem_addr_q;
  logic        cpu_reset_q;
  logic        done_q;
  logic        error_q;
  logic [15:0] word_count_q;
  logic [15:0] len_q;
  logic [7:0]  xor_q;

  logic        accept;
  logic        restart;
  logic [7:0]  xor_with_byte;
  logic [15:0] word_count_inc;

  // in_ready_q mirrors "state is one of the byte-accepting states", so this
  // is exactly the stream transfer condition.
  assign accept         = bus.in_valid && in_ready_q;
  assign xor_with_byte  = xor_q ^ bus.in_data;
  assign word_count_inc = word_count_q + 16'd1;

  // A (re)load may begin only from the resting states. IDLE is only ever
  // reached through reset, so AUTO_START there means "first clock after reset".
  always_comb begin
    restart = 1'b0;
    case (state_q)
      S_IDLE:           restart = bus.start || (AUTO_START != 0);
      S_DONE, S_ERROR:  restart = bus.start;
      default:          restart = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_data_q   <= 16'h0000;
      mem_addr_q   <= BASE_ADDR;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= 16'h0000;
      len_q        <= 16'h0000;
      xor_q        <= 8'h00;
    end else begin
      // Write enable is a single-cycle pulse covering only the WRITE state.
      mem_we_q <= 1'b0;

      if (restart) begin
        state_q      <= S_LEN_LO;
        in_ready_q   <= 1'b1;
        mem_addr_q   <= BASE_ADDR;
        cpu_reset_q  <= 1'b1;
        done_q       <= 1'b0;
        error_q      <= 1'b0;
        word_count_q <= 16'h0000;
        xor_q        <= 8'h00;
      end else begin
        case (state_q)
          S_LEN_LO: begin
            if (accept) begin
              len_q[7:0] <= bus.in_data;
              xor_q      <= xor_with_byte;
              state_q    <= S_LEN_HI;
            end
          end

          S_LEN_HI: begin
            if (accept) begin
              len_q[15:8] <= bus.in_data;
              xor_q       <= xor_with_byte;
              // An empty image goes straight to the checksum byte.
              if ({bus.in_data, len_q[7:0]} == 16'h0000) begin
                state_q <= S_CHECK;
              end else begin
                state_q <= S_DATA_LO;
              end
            end
          end

          S_DATA_LO: begin
            if (accept) begin
              mem_data_q[7:0] <= bus.in_data;
              xor_q           <= xor_with_byte;
              state_q         <= S_DATA_HI;
            end
          end

          S_DATA_HI: begin
            if (accept) begin
              mem_data_q[15:8] <= bus.in_data;
              xor_q            <= xor_with_byte;
              mem_we_q         <= 1'b1;
              in_ready_q       <= 1'b0;
              state_q          <= S_WRITE;
            end
          end

          S_WRITE: begin
            // Address wraps naturally at 16 bits.
            mem_addr_q   <= mem_addr_q + 16'd2;
            word_count_q <= word_count_inc;
            in_ready_q   <= 1'b1;
            if (word_count_inc == len_q) begin
              state_q <= S_CHECK;
            end else begin
              state_q <= S_DATA_LO;
            end
          end

          S_CHECK: begin
            if (accept) begin
              in_ready_q <= 1'b0;
              if (xor_with_byte == 8'h00) begin
                done_q      <= 1'b1;
                cpu_reset_q <= 1'b0;
                state_q     <= S_DONE;
              end else begin
                error_q <= 1'b1;
                state_q <= S_ERROR;
              end
            end
          end

          default: begin
            // IDLE, DONE and ERROR hold until a restart.
            state_q <= state_q;
          end
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_data   = mem_data_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_text_loader.sv
// tb/tb_text_loader.sv - directed self-checking bench for text_loader
module tb_text_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   failed = 0;
  int   viol = 0;

  logic [31:0] w1[$];
  logic [31:0] w2[$];
  logic [7:0]  stim[$];

  text_loader_if b1();
  text_loader_if b2();

  text_loader #(.BASE_ADDR(16'h0000), .AUTO_START(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );
  text_loader #(.BASE_ADDR(16'hFFFE), .AUTO_START(0)) dut2 (
    .clk(clk), .reset(reset), .bus(b2)
  );

  always #5 clk = ~clk;

  // Record every write cycle as {addr, data}; in_ready must be low in each.
  always @(negedge clk) begin
    if (b1.mem_we === 1'b1) begin
      w1.push_back({b1.mem_addr, b1.mem_data});
      if (b1.in_ready !== 1'b0) viol++;
    end
    if (b2.mem_we === 1'b1) begin
      w2.push_back({b2.mem_addr, b2.mem_data});
      if (b2.in_ready !== 1'b0) viol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send(input int which, input logic [7:0] b);
    int   n;
    logic rdy;
    n = 0;
    if (which == 1) begin b1.in_data = b; b1.in_valid = 1'b1; end
    else            begin b2.in_data = b; b2.in_valid = 1'b1; end
    rdy = (which == 1) ? b1.in_ready : b2.in_ready;
    while (rdy !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      rdy = (which == 1) ? b1.in_ready : b2.in_ready;
    end
    check("byte_ready", rdy, 1'b1);
    @(negedge clk);
    if (which == 1) b1.in_valid = 1'b0;
    else            b2.in_valid = 1'b0;
  endtask

  task automatic send_stream(input int which, input int maxgap);
    foreach (stim[i]) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
      send(which, stim[i]);
    end
  endtask

  task automatic pulse_start(input int which);
    if (which == 1) b1.start = 1'b1; else b2.start = 1'b1;
    @(negedge clk);
    if (which == 1) b1.start = 1'b0; else b2.start = 1'b0;
  endtask

  initial begin
    b1.start = 1'b0; b1.in_valid = 1'b0; b1.in_data = 8'h00;
    b2.start = 1'b0; b2.in_valid = 1'b0; b2.in_data = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_in_ready",  b1.in_ready, 1'b0);
    check("rst_mem_we",    b1.mem_we, 1'b0);
    check("rst_mem_data",  b1.mem_data, 16'h0000);
    check("rst_mem_addr",  b1.mem_addr, 16'h0000);
    check("rst_cpu_reset", b1.cpu_reset, 1'b1);
    check("rst_done",      b1.done, 1'b0);
    check("rst_error",     b1.error, 1'b0);
    check("rst_wc",        b1.word_count, 16'h0000);
    check("rst2_mem_addr", b2.mem_addr, 16'hFFFE);

    reset = 1'b0;
    @(negedge clk);
    check("auto_start_ready", b1.in_ready, 1'b1);
    check("manual_idle",      b2.in_ready, 1'b0);

    // Back-to-back good image; checksum 02^00^13^00^37^12 = 34
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h37, 8'h12, 8'h34};
    send_stream(1, 0);
    check("t1_nwrites",   w1.size(), 2);
    check("t1_w0",        w1[0], 32'h0000_0013);
    check("t1_w1",        w1[1], 32'h0002_1237);
    check("t1_done",      b1.done, 1'b1);
    check("t1_cpu_reset", b1.cpu_reset, 1'b0);
    check("t1_error",     b1.error, 1'b0);
    check("t1_wc",        b1.word_count, 16'd2);
    check("t1_in_ready",  b1.in_ready, 1'b0);
    check("t1_mem_addr",  b1.mem_addr, 16'h0004);

    // Bad checksum, then restart with the good one
    pulse_start(1);
    check("t2_restart_done", b1.done, 1'b0);
    check("t2_restart_cpu",  b1.cpu_reset, 1'b1);
    check("t2_restart_wc",   b1.word_count, 16'd0);
    check("t2_restart_addr", b1.mem_addr, 16'h0000);
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h37, 8'h12, 8'h33};
    send_stream(1, 0);
    check("t2_nwrites",   w1.size(), 4);
    check("t2_error",     b1.error, 1'b1);
    check("t2_done",      b1.done, 1'b0);
    check("t2_cpu_reset", b1.cpu_reset, 1'b1);
    check("t2_wc",        b1.word_count, 16'd2);
    pulse_start(1);
    check("t2_error_clr", b1.error, 1'b0);
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h37, 8'h12, 8'h34};
    send_stream(1, 0);
    check("t2_reload_done",  b1.done, 1'b1);
    check("t2_reload_error", b1.error, 1'b0);
    check("t2_reload_nw",    w1.size(), 6);

    // Empty image
    pulse_start(1);
    stim = '{8'h00, 8'h00, 8'h00};
    send_stream(1, 0);
    check("t3_nwrites",  w1.size(), 6);
    check("t3_done",     b1.done, 1'b1);
    check("t3_wc",       b1.word_count, 16'd0);
    check("t3_mem_addr", b1.mem_addr, 16'h0000);

    // Random gaps, with an ignored start pulse in the middle of the load
    pulse_start(1);
    stim = '{8'h02, 8'h00, 8'h13};
    send_stream(1, 5);
    pulse_start(1);
    stim = '{8'h00, 8'h37, 8'h12, 8'h34};
    send_stream(1, 5);
    check("t4_nwrites", w1.size(), 8);
    check("t4_w0",      w1[6], 32'h0000_0013);
    check("t4_w1",      w1[7], 32'h0002_1237);
    check("t4_done",    b1.done, 1'b1);
    check("t4_cpu",     b1.cpu_reset, 1'b0);
    check("t4_wc",      b1.word_count, 16'd2);

    // Asynchronous reset mid-load, then auto-started reload
    pulse_start(1);
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h37};
    send_stream(1, 0);
    #2 reset = 1'b1;
    #1;
    check("t5_in_ready", b1.in_ready, 1'b0);
    check("t5_mem_we",   b1.mem_we, 1'b0);
    check("t5_mem_data", b1.mem_data, 16'h0000);
    check("t5_mem_addr", b1.mem_addr, 16'h0000);
    check("t5_wc",       b1.word_count, 16'd0);
    check("t5_cpu",      b1.cpu_reset, 1'b1);
    check("t5_done",     b1.done, 1'b0);
    check("t5_nwrites",  w1.size(), 9);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h37, 8'h12, 8'h34};
    send_stream(1, 0);
    check("t5_reload_nw", w1.size(), 11);
    check("t5_reload_w0", w1[9], 32'h0000_0013);
    check("t5_reload_w1", w1[10], 32'h0002_1237);
    check("t5_done2",     b1.done, 1'b1);
    check("t5_wc2",       b1.word_count, 16'd2);

    // Address wrap from FFFE on the manual-start instance; chk 02^AA^55^01^80 = 7C
    check("t6_idle_ready", b2.in_ready, 1'b0);
    check("t6_idle_addr",  b2.mem_addr, 16'hFFFE);
    pulse_start(2);
    stim = '{8'h02, 8'h00, 8'hAA, 8'h55, 8'h01, 8'h80, 8'h7C};
    send_stream(2, 2);
    check("t6_nwrites",  w2.size(), 2);
    check("t6_w0",       w2[0], 32'hFFFE_55AA);
    check("t6_w1",       w2[1], 32'h0000_8001);
    check("t6_done",     b2.done, 1'b1);
    check("t6_mem_addr", b2.mem_addr, 16'h0002);
    check("t6_wc",       b2.word_count, 16'd2);

    check("write_cycle_ready_low", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
